// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU issue/writeback stage:
//   - opcode encodings seen on the 16-bit instruction and on the ALU's ins bus
//   - bit positions of the flags returned by the ALU
//   - instruction field positions
//   - FSM state encoding of the issue stage
//   - small helpers for immediate extension and write-enable decoding
// ----------------------------------------------------------------------------
package alu_pkg;

    // Opcodes. 10..14 are reserved and behave like NOP with no writeback.
    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_MUL = 4'd3;
    localparam logic [3:0] OP_DIV = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_AND = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_XOR = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;
    localparam logic [3:0] OP_RSV_LO = 4'd10;
    localparam logic [3:0] OP_RSV_HI = 4'd14;
    localparam logic [3:0] OP_LDI = 4'd15;

    // Flag bit indices within alu_flags = {div_err, overflow, carry}.
    localparam int FLAG_C = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_E = 2;

    // Instruction field positions.
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RA_MSB  = 8;
    localparam int RA_LSB  = 6;
    localparam int RB_MSB  = 5;
    localparam int RB_LSB  = 3;
    localparam int IMM_MSB = 8;

    // Issue stage FSM encoding.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    // Sign-extend the 9-bit LDI immediate to the 16-bit datapath.
    function automatic logic [15:0] sext_imm9(input logic [8:0] imm);
        return {{7{imm[8]}}, imm};
    endfunction

    // Decide whether an instruction writes its destination register.
    // NOP, reserved opcodes and a faulting DIV leave the register file alone.
    function automatic logic op_writes(input logic [3:0] op, input logic div_err);
        logic no_write;
        no_write = (op == OP_NOP)
                || ((op >= OP_RSV_LO) && (op <= OP_RSV_HI))
                || ((op == OP_DIV) && div_err);
        return !no_write;
    endfunction

endpackage

// File: rtl/regfile_8x16.sv
// ----------------------------------------------------------------------------
// regfile_8x16
//   General-purpose register file with R0 hard-wired to zero.
//   Ports:
//     clk, rst          clock and asynchronous active-high reset (clears all)
//     we, waddr, wdata  synchronous write port (writes to R0 are dropped)
//     raddr_a/rdata_a   combinational read port A
//     raddr_b/rdata_b   combinational read port B
//     dbg_sel/dbg_data  combinational debug read port
// ----------------------------------------------------------------------------
module regfile_8x16
    import alu_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int REG_CNT = 8,
    localparam int AW     = $clog2(REG_CNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [AW-1:0]     raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic [AW-1:0]     dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs [REG_CNT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    // R0 is forced to zero on every read port so it never depends on storage.
    assign rdata_a  = (raddr_a == '0) ? '0 : regs[raddr_a];
    assign rdata_b  = (raddr_b == '0) ? '0 : regs[raddr_b];
    assign dbg_data = (dbg_sel == '0) ? '0 : regs[dbg_sel];

endmodule

// File: rtl/alu_issue.sv
// ----------------------------------------------------------------------------
// alu_issue
//   Issue/writeback stage wrapped around an external combinational 16-bit ALU.
//   One instruction in flight at a time: IDLE -> EXEC -> WB -> IDLE.
//
//   Handshake: an instruction transfers on a rising clk edge where both
//   instr_valid and instr_ready are high. instr_ready is high only in IDLE and
//   depends on state alone (never on instr_valid). instr_valid seen while
//   instr_ready is low is ignored; nothing is buffered, so the producer must
//   keep the word stable until it observes the transfer.
//
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     instr_valid/instr_ready  instruction handshake
//     instr                    [15:12] op, [11:9] rd, [8:6] ra, [5:3] rb,
//                              LDI uses [8:0] as a signed imm9
//     alu_a, alu_b, alu_ins    registered operands/opcode to the ALU
//     alu_out, alu_flags       ALU result and {div_err, overflow, carry}
//     done                     one-cycle pulse in the writeback cycle
//     flag_c, flag_v           carry/overflow status, updated by ADD/SUB only
//     flag_e                   sticky divide error, cleared by err_clr
//     err_clr                  synchronous clear of flag_e (a new error wins)
//     dbg_sel, dbg_data        combinational register file peek
//
//   The FSM state is held in the signal `state` (type state_t) for probing.
// ----------------------------------------------------------------------------
module alu_issue
    import alu_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int REG_CNT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_ins,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [2:0]        alu_flags,
    output logic              done,
    output logic              flag_c,
    output logic              flag_v,
    output logic              flag_e,
    input  logic              err_clr,
    input  logic [2:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    state_t state;
    state_t next_state;

    // Instruction fields
    logic [3:0]        op_in;
    logic [2:0]        rd_in;
    logic [2:0]        ra_in;
    logic [2:0]        rb_in;
    logic [8:0]        imm_in;

    // Latched instruction context and captured ALU response
    logic [3:0]        op_q;
    logic [2:0]        rd_q;
    logic [DATA_W-1:0] res_q;
    logic [2:0]        flg_q;

    // Register file connections
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;
    logic              rf_we;

    logic              accept;
    logic              in_wb;

    assign op_in  = instr[OP_MSB:OP_LSB];
    assign rd_in  = instr[RD_MSB:RD_LSB];
    assign ra_in  = instr[RA_MSB:RA_LSB];
    assign rb_in  = instr[RB_MSB:RB_LSB];
    assign imm_in = instr[IMM_MSB:0];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        instr_ready = 1'b0;
        done        = 1'b0;
        case (state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                next_state = S_WB;
            end
            S_WB: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    assign accept = (state == S_IDLE) && instr_valid;
    assign in_wb  = (state == S_WB);

    // ------------------------------------------------------------------
    // Operand latches and result capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_ins <= OP_NOP;
            op_q    <= OP_NOP;
            rd_q    <= '0;
            res_q   <= '0;
            flg_q   <= '0;
        end else begin
            if (accept) begin
                op_q  <= op_in;
                rd_q  <= rd_in;
                alu_b <= rdata_b;
                if (op_in == OP_LDI) begin
                    // LDI bypasses the ALU: the immediate rides on alu_a and
                    // the ALU is told to do nothing.
                    alu_a   <= sext_imm9(imm_in);
                    alu_ins <= OP_NOP;
                end else begin
                    alu_a   <= rdata_a;
                    alu_ins <= op_in;
                end
            end
            if (state == S_EXEC) begin
                res_q <= (op_q == OP_LDI) ? alu_a : alu_out;
                flg_q <= alu_flags;
            end
        end
    end

    // ------------------------------------------------------------------
    // Status flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_c <= 1'b0;
            flag_v <= 1'b0;
            flag_e <= 1'b0;
        end else begin
            if (in_wb && ((op_q == OP_ADD) || (op_q == OP_SUB))) begin
                flag_c <= flg_q[FLAG_C];
                flag_v <= flg_q[FLAG_V];
            end
            // A divide error in the same cycle as err_clr keeps flag_e set.
            if (in_wb && (op_q == OP_DIV) && flg_q[FLAG_E]) begin
                flag_e <= 1'b1;
            end else if (err_clr) begin
                flag_e <= 1'b0;
            end
        end
    end

    assign rf_we = in_wb && op_writes(op_q, flg_q[FLAG_E]);

    regfile_8x16 #(
        .DATA_W  (DATA_W),
        .REG_CNT (REG_CNT)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (rf_we),
        .waddr    (rd_q),
        .wdata    (res_q),
        .raddr_a  (ra_in),
        .rdata_a  (rdata_a),
        .raddr_b  (rb_in),
        .rdata_b  (rdata_b),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );

endmodule

// File: tb/tb_alu_issue.sv
`timescale 1ns/1ps
module tb_alu_issue;
    import alu_pkg::*;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_ins;
    logic [15:0] alu_out;
    logic [2:0]  alu_flags;
    logic        done;
    logic        flag_c;
    logic        flag_v;
    logic        flag_e;
    logic        err_clr;
    logic [2:0]  dbg_sel;
    logic [15:0] dbg_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    alu_issue dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ins     (alu_ins),
        .alu_out     (alu_out),
        .alu_flags   (alu_flags),
        .done        (done),
        .flag_c      (flag_c),
        .flag_v      (flag_v),
        .flag_e      (flag_e),
        .err_clr     (err_clr),
        .dbg_sel     (dbg_sel),
        .dbg_data    (dbg_data)
    );

    // ------------------------------------------------------------------
    // Behavioural 16-bit ALU standing in for the real one
    // carry on SUB is the borrow; CMP returns -1/0/+1 on signed compare.
    // ------------------------------------------------------------------
    logic [16:0] alu_wide;
    always_comb begin
        alu_out   = '0;
        alu_flags = '0;
        alu_wide  = '0;
        case (alu_ins)
            OP_ADD: begin
                alu_wide     = {1'b0, alu_a} + {1'b0, alu_b};
                alu_out      = alu_wide[15:0];
                alu_flags[0] = alu_wide[16];
                alu_flags[1] = (alu_a[15] == alu_b[15]) && (alu_wide[15] != alu_a[15]);
            end
            OP_SUB: begin
                alu_wide     = {1'b0, alu_a} - {1'b0, alu_b};
                alu_out      = alu_wide[15:0];
                alu_flags[0] = alu_wide[16];
                alu_flags[1] = (alu_a[15] != alu_b[15]) && (alu_wide[15] != alu_a[15]);
            end
            OP_MUL: alu_out = alu_a * alu_b;
            OP_DIV: begin
                if (alu_b == 16'h0000) alu_flags[2] = 1'b1;
                else                   alu_out = alu_a / alu_b;
            end
            OP_OR:  alu_out = alu_a | alu_b;
            OP_AND: alu_out = alu_a & alu_b;
            OP_NOT: alu_out = ~alu_a;
            OP_XOR: alu_out = alu_a ^ alu_b;
            OP_CMP: begin
                if ($signed(alu_a) < $signed(alu_b))      alu_out = 16'hFFFF;
                else if ($signed(alu_a) > $signed(alu_b)) alu_out = 16'h0001;
                else                                      alu_out = 16'h0000;
            end
            default: alu_out = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Scoreboard: {rd, expected R[rd] after writeback}
    // ------------------------------------------------------------------
    logic [18:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic c, input logic v, input logic e);
        check_bit({tag, "_c"}, flag_c, c);
        check_bit({tag, "_v"}, flag_v, v);
        check_bit({tag, "_e"}, flag_e, e);
    endtask

    // Pop every pending entry and compare against the debug read port.
    task automatic drain();
        logic [18:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            dbg_sel = e[18:16];
            @(negedge clk);
            check16($sformatf("wb_R%0d", e[18:16]), dbg_data, e[15:0]);
        end
    endtask

    function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [8:0] imm);
        return {OP_LDI, rd, imm};
    endfunction

    function automatic logic [15:0] rrr(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] ra, input logic [2:0] rb);
        return {op, rd, ra, rb, 3'b000};
    endfunction

    // ------------------------------------------------------------------
    // Driver: issue one instruction, check EXEC latches, latency, result
    // ------------------------------------------------------------------
    task automatic issue(input logic [15:0] word, input logic [15:0] exp_val);
        int          cyc;
        logic [3:0]  op;
        logic [3:0]  exp_ins;
        logic [15:0] exp_imm;
        op      = word[15:12];
        exp_ins = (op == OP_LDI) ? OP_NOP : op;
        exp_imm = {{7{word[8]}}, word[8:0]};
        @(negedge clk);
        instr       = word;
        instr_valid = 1'b1;
        cyc = 0;
        while (!instr_ready && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check_bit("issue_ready", instr_ready, 1'b1);
        exp_q.push_back({word[11:9], exp_val});
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = '0;
        @(negedge clk);
        cyc = 2;
        check16("exec_alu_ins", {12'h000, alu_ins}, {12'h000, exp_ins});
        if (op == OP_LDI) check16("exec_ldi_imm", alu_a, exp_imm);
        while (!done && cyc < 12) begin
            @(negedge clk);
            cyc++;
        end
        check16("done_latency", cyc[15:0], 16'd3);
        drain();
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int acc;
        int dones;
        int cyc;
        logic [15:0] word_a;
        logic [15:0] word_b;

        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        err_clr     = 1'b0;
        dbg_sel     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check_bit("rst_ready", instr_ready, 1'b1);
        check_bit("rst_done", done, 1'b0);
        check_flags("rst_flags", 1'b0, 1'b0, 1'b0);
        check16("rst_alu_a", alu_a, 16'h0000);
        check16("rst_alu_b", alu_b, 16'h0000);
        check16("rst_alu_ins", {12'h000, alu_ins}, 16'h0000);
        for (int r = 0; r < 8; r++) begin
            dbg_sel = r[2:0];
            #1;
            check16($sformatf("rst_R%0d", r), dbg_data, 16'h0000);
        end

        // 1. LDI positive and negative immediates, then ADD with carry out
        issue(ldi(3'd1, 9'd5), 16'h0005);
        issue(ldi(3'd2, 9'h1FD), 16'hFFFD);
        issue(rrr(OP_ADD, 3'd3, 3'd1, 3'd2), 16'h0002);
        check_flags("add_carry", 1'b1, 1'b0, 1'b0);

        // 2. Build 0x7FFF, then signed overflow on ADD; XOR leaves flags alone
        issue(ldi(3'd1, 9'h080), 16'h0080);
        issue(rrr(OP_MUL, 3'd1, 3'd1, 3'd1), 16'h4000);
        issue(rrr(OP_ADD, 3'd1, 3'd1, 3'd1), 16'h8000);
        issue(ldi(3'd2, 9'd1), 16'h0001);
        issue(rrr(OP_SUB, 3'd1, 3'd1, 3'd2), 16'h7FFF);
        issue(ldi(3'd6, 9'h1FF), 16'hFFFF);
        issue(rrr(OP_ADD, 3'd7, 3'd6, 3'd2), 16'h0000);
        check_flags("pre_ovf", 1'b1, 1'b0, 1'b0);
        issue(rrr(OP_ADD, 3'd3, 3'd1, 3'd2), 16'h8000);
        check_flags("add_ovf", 1'b0, 1'b1, 1'b0);
        issue(rrr(OP_XOR, 3'd4, 3'd1, 3'd2), 16'h7FFE);
        check_flags("xor_hold", 1'b0, 1'b1, 1'b0);

        // 3. Divide by zero: no write, sticky error, clear, set-wins
        issue(ldi(3'd1, 9'd10), 16'h000A);
        issue(rrr(OP_DIV, 3'd4, 3'd1, 3'd0), 16'h7FFE);
        check_flags("div0", 1'b0, 1'b1, 1'b1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_bit("err_clr", flag_e, 1'b0);
        issue(ldi(3'd2, 9'd3), 16'h0003);
        issue(rrr(OP_DIV, 3'd5, 3'd1, 3'd2), 16'h0003);
        check_bit("div_ok_e", flag_e, 1'b0);
        err_clr = 1'b1;
        issue(rrr(OP_DIV, 3'd4, 3'd1, 3'd0), 16'h7FFE);
        check_bit("set_wins", flag_e, 1'b1);
        err_clr = 1'b0;
        @(negedge clk);
        check_bit("sticky_e", flag_e, 1'b1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_bit("err_clr2", flag_e, 1'b0);

        // 4. Signed compare
        issue(ldi(3'd1, 9'h1FF), 16'hFFFF);
        issue(ldi(3'd2, 9'd1), 16'h0001);
        issue(rrr(OP_CMP, 3'd5, 3'd1, 3'd2), 16'hFFFF);
        issue(ldi(3'd1, 9'd2), 16'h0002);
        issue(rrr(OP_CMP, 3'd5, 3'd1, 3'd2), 16'h0001);
        check_flags("cmp_hold", 1'b0, 1'b1, 1'b0);

        // 5. instr_valid held for 5 cycles with two instructions queued up
        word_a = rrr(OP_OR, 3'd6, 3'd1, 3'd2);
        word_b = rrr(OP_NOT, 3'd7, 3'd1, 3'd0);
        acc    = 0;
        dones  = 0;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            instr_valid = 1'b1;
            instr       = (acc == 0) ? word_a : word_b;
            check_bit($sformatf("hold_ready_c%0d", c), instr_ready, (c == 0) || (c == 3));
            if (done) dones++;
            if (instr_ready) begin
                if (acc == 0) exp_q.push_back({3'd6, 16'h0003});
                else          exp_q.push_back({3'd7, 16'hFFFD});
                acc++;
            end
            @(negedge clk);
        end
        instr_valid = 1'b0;
        instr       = '0;
        cyc = 0;
        while (!done && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        if (done) dones++;
        check16("hold_accepts", acc[15:0], 16'd2);
        check16("hold_dones", dones[15:0], 16'd2);
        drain();

        // 6. Reset during EXEC aborts the instruction and clears everything
        @(negedge clk);
        instr       = rrr(OP_ADD, 3'd6, 3'd1, 3'd1);
        instr_valid = 1'b1;
        check_bit("abort_ready", instr_ready, 1'b1);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = '0;
        @(negedge clk);
        check16("abort_in_exec", {14'h0, dut.state}, {14'h0, S_EXEC});
        rst = 1'b1;
        #1;
        check16("abort_state", {14'h0, dut.state}, {14'h0, S_IDLE});
        dones = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) dones++;
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done) dones++;
        end
        check16("abort_no_done", dones[15:0], 16'd0);
        check_bit("abort_ready_idle", instr_ready, 1'b1);
        check_flags("abort_flags", 1'b0, 1'b0, 1'b0);
        dbg_sel = 3'd6;
        #1;
        check16("abort_R6", dbg_data, 16'h0000);
        dbg_sel = 3'd1;
        #1;
        check16("abort_R1", dbg_data, 16'h0000);

        // R0 discards writes and reads as zero when used as an operand
        issue(ldi(3'd0, 9'd5), 16'h0000);
        issue(ldi(3'd1, 9'd7), 16'h0007);
        issue(rrr(OP_ADD, 3'd2, 3'd0, 3'd1), 16'h0007);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
